conv_frame_sequencer: RTL and testbench
=======================================

// Module: conv_frame_sequencer
// PURPOSE
//  Sequences one convolution job around the conv2d engine: loads a host image into the source
//  RAM, pulses start, muxes the source-RAM port to the engine, forwards result writes to the
//  destination RAM and detects completion or timeout. Sits between host/testbench and conv2d.
// PARAMETERS
//  DW         12      pixel width (matches conv2d d_in/d_out)
//  AW         17      address width (matches ReadAddress/WriteAddress)
//  IMG_PIXELS 25      pixels per frame loaded by host (5x5 test image)
//  TIMEOUT    65535   max RUN cycles before error abort
// PORTS
//  clk           in   1   system clock, rising edge
//  rst           in   1   synchronous, active-high reset
//  host_load_req in   1   request new frame load (level sampled per cycle)
//  host_wr_en    in   1   host pixel valid during LOAD
//  host_wr_data  in   DW  host pixel
//  host_go       in   1   launch convolution on loaded frame
//  busy          out  1   high in LOAD, START, RUN
//  done          out  1   one-cycle pulse when job ends
//  error         out  1   sticky timeout flag
//  conv_start    out  1   start pulse to conv2d
//  conv_ready    in   1   conv2d ready
//  conv_rd_addr  in   AW  conv2d ReadAddress
//  conv_wr_addr  in   AW  conv2d WriteAddress
//  conv_d_out    in   DW  conv2d d_out
//  conv_d_in     out  DW  pixel to conv2d d_in (= src_rdata, combinational)
//  src_we        out  1   source RAM write enable
//  src_addr      out  AW  source RAM address
//  src_wdata     out  DW  source RAM write data
//  src_rdata     in   DW  source RAM async read data
//  dst_we/dst_addr/dst_wdata  out 1/AW/DW  destination RAM write port
// BEHAVIOUR
//  States: IDLE, LOAD, LOADED, START, RUN, DONE. Reset (any state, mid-job included): state=IDLE,
//   load_cnt=0, timer=0, ready_q=0, error=0; busy=done=conv_start=src_we=dst_we=0, src_addr=0.
//  IDLE: host_load_req -> LOAD (load_cnt=0, error cleared). host_go and host_wr_en ignored.
//  LOAD: src_addr=load_cnt, src_wdata=host_wr_data, src_we=host_wr_en. Each host_wr_en cycle
//   increments load_cnt; write with load_cnt==IMG_PIXELS-1 -> LOADED. host_load_req ignored.
//  LOADED: host_load_req -> LOAD (wins over simultaneous host_go); else host_go -> START.
//  START: conv_start=1 exactly one cycle; -> RUN, timer=0.
//  RUN: src_addr=conv_rd_addr, src_we=0; dst_we=1, dst_addr=conv_wr_addr, dst_wdata=conv_d_out
//   every cycle (last write to an address wins). ready_q<=conv_ready each cycle.
//   Completion = rising edge (conv_ready & ~ready_q); a ready already high on RUN entry does not
//   complete the job. Completion -> DONE. Else timer==TIMEOUT-1 -> DONE with error<=1.
//  DONE: done=1 for one cycle, dst_we=0; -> LOADED (frame stays resident for re-run via host_go).
//  Outside RUN: dst_we=0; outside START: conv_start=0; outside LOAD: src_we=0.
//  conv_d_in = src_rdata in all states (engine sees 0-latency read, as the engine expects).
//  load_cnt and timer never wrap: held at terminal value by the state exit.
//  error sticky until next LOAD entry or rst.
// TESTING
//  1 rst high 2 cycles -> busy,done,error,conv_start,src_we,dst_we all 0; state IDLE.
//  2 load_req, 25 host_wr_en pixels 0..24 with gaps -> src_we only on wr_en cycles, addr 0..24,
//    LOADED after 25th; 26th wr_en ignored.
//  3 host_go -> conv_start high exactly 1 cycle; model engine asserts ready 40 cycles later ->
//    done pulse 1 cycle, error=0, busy low, dst writes mirror conv_wr_addr/conv_d_out.
//  4 conv_ready held high through START/RUN entry -> no done until low-then-high edge.
//  5 TIMEOUT=16, ready never rises -> done + error=1 after 16 RUN cycles; next load clears error.
//  6 rst asserted mid-RUN -> next cycle IDLE, conv_start=0, dst_we=0; host_go then ignored.

Source files
------------

// File: rtl/conv_frame_sequencer.sv
// Job sequencer around the conv2d engine: host frame load into source RAM, start pulse,
// source-port mux to the engine, result forwarding to destination RAM, completion/timeout.
module conv_frame_sequencer #(
  parameter int DW         = 12,
  parameter int AW         = 17,
  parameter int IMG_PIXELS = 25,
  parameter int TIMEOUT    = 65535
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          host_load_req_i,
  input  logic          host_wr_en_i,
  input  logic [DW-1:0] host_wr_data_i,
  input  logic          host_go_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o,
  output logic          conv_start_o,
  input  logic          conv_ready_i,
  input  logic [AW-1:0] conv_rd_addr_i,
  input  logic [AW-1:0] conv_wr_addr_i,
  input  logic [DW-1:0] conv_d_out_i,
  output logic [DW-1:0] conv_d_in_o,
  output logic          src_we_o,
  output logic [AW-1:0] src_addr_o,
  output logic [DW-1:0] src_wdata_o,
  input  logic [DW-1:0] src_rdata_i,
  output logic          dst_we_o,
  output logic [AW-1:0] dst_addr_o,
  output logic [DW-1:0] dst_wdata_o
);

  localparam int CW = $clog2(IMG_PIXELS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LOADED, S_START, S_RUN, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] load_cnt_q, load_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ready_q;
  logic          error_q, error_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      load_cnt_q <= '0;
      timer_q    <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      timer_q    <= timer_d;
      ready_q    <= conv_ready_i;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    timer_d      = timer_q;
    error_d      = error_q;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    conv_start_o = 1'b0;
    src_we_o     = 1'b0;
    src_addr_o   = '0;
    src_wdata_o  = '0;
    dst_we_o     = 1'b0;
    dst_addr_o   = '0;
    dst_wdata_o  = '0;
    case (state_q)
      S_IDLE: begin
        if (host_load_req_i) begin
          state_d    = S_LOAD;
          load_cnt_d = '0;
          error_d    = 1'b0;
        end
      end
      S_LOAD: begin
        busy_o      = 1'b1;
        src_addr_o  = AW'(load_cnt_q);
        src_wdata_o = host_wr_data_i;
        src_we_o    = host_wr_en_i;
        if (host_wr_en_i) begin
          if (load_cnt_q == CW'(IMG_PIXELS - 1)) state_d = S_LOADED;
          else load_cnt_d = load_cnt_q + 1'b1;
        end
      end
      S_LOADED: begin
        // A reload request takes priority over launching the resident frame.
        if (host_load_req_i) begin
          state_d    = S_LOAD;
          load_cnt_d = '0;
          error_d    = 1'b0;
        end else if (host_go_i) begin
          state_d = S_START;
        end
      end
      S_START: begin
        busy_o       = 1'b1;
        conv_start_o = 1'b1;
        timer_d      = '0;
        state_d      = S_RUN;
      end
      S_RUN: begin
        busy_o      = 1'b1;
        src_addr_o  = conv_rd_addr_i;
        dst_we_o    = 1'b1;
        dst_addr_o  = conv_wr_addr_i;
        dst_wdata_o = conv_d_out_i;
        // ready_q tracks ready during START too, so a level already high on entry is no edge.
        if (conv_ready_i && !ready_q) begin
          state_d = S_DONE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          error_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_LOADED;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign error_o     = error_q;
  assign conv_d_in_o = src_rdata_i;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Randomized bench for conv_frame_sequencer: scenario-level model sets expected outputs per
// cycle, one compare process checks them, literal latencies pin the model.
module tb_conv_frame_sequencer;
  localparam int DW = 12, AW = 17, NPIX = 25, TO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, load_req, wr_en, go, conv_ready;
  logic [DW-1:0] wr_data, d_out, src_rdata;
  logic [AW-1:0] rd_addr, wr_addr;
  logic busy, done, error, conv_start, src_we, dst_we;
  logic [DW-1:0] d_in, src_wdata, dst_wdata;
  logic [AW-1:0] src_addr, dst_addr;

  conv_frame_sequencer #(.DW(DW), .AW(AW), .IMG_PIXELS(NPIX), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .host_load_req_i(load_req), .host_wr_en_i(wr_en),
    .host_wr_data_i(wr_data), .host_go_i(go), .busy_o(busy), .done_o(done),
    .error_o(error), .conv_start_o(conv_start), .conv_ready_i(conv_ready),
    .conv_rd_addr_i(rd_addr), .conv_wr_addr_i(wr_addr), .conv_d_out_i(d_out),
    .conv_d_in_o(d_in), .src_we_o(src_we), .src_addr_o(src_addr), .src_wdata_o(src_wdata),
    .src_rdata_i(src_rdata), .dst_we_o(dst_we), .dst_addr_o(dst_addr), .dst_wdata_o(dst_wdata)
  );

  int n_chk = 0, n_fail = 0;
  bit chk_on = 1'b0;
  bit m_err = 1'b0;
  logic e_busy, e_done, e_start, e_swe, e_dwe;
  logic [AW-1:0] e_saddr, e_daddr;
  logic [DW-1:0] e_swdata, e_dwdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_on) begin
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("error", 32'(error), 32'(m_err));
    chk("conv_start", 32'(conv_start), 32'(e_start));
    chk("src_we", 32'(src_we), 32'(e_swe));
    chk("dst_we", 32'(dst_we), 32'(e_dwe));
    chk("src_addr", 32'(src_addr), 32'(e_saddr));
    chk("conv_d_in", 32'(d_in), 32'(src_rdata));
    if (e_swe) chk("src_wdata", 32'(src_wdata), 32'(e_swdata));
    if (e_dwe) begin
      chk("dst_addr", 32'(dst_addr), 32'(e_daddr));
      chk("dst_wdata", 32'(dst_wdata), 32'(e_dwdata));
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic noise;
    rd_addr = AW'($urandom); wr_addr = AW'($urandom);
    d_out = DW'($urandom); src_rdata = DW'($urandom); wr_data = DW'($urandom);
  endtask

  task automatic exp_set(input logic b, input logic dn, input logic st, input logic swe,
                         input logic [AW-1:0] sa, input logic [DW-1:0] sd, input logic dwe);
    e_busy = b; e_done = dn; e_start = st; e_swe = swe; e_saddr = sa; e_swdata = sd;
    e_dwe = dwe; e_daddr = wr_addr; e_dwdata = d_out;
  endtask

  // Engine ready waveform: optionally high through START and RUN 0..2, then rises at RUN index r.
  function automatic bit rdy(input int i, input int r, input bit pre);
    if (pre && i <= 2) return 1'b1;
    return i >= r;
  endfunction

  task automatic do_load(input bit with_go);
    noise; load_req = 1'b1; go = with_go; wr_en = 1'b0;
    exp_set(0, 0, 0, 0, '0, '0, 0); tick;
    m_err = 1'b0;
    for (int k = 0; k < NPIX; k++) begin
      repeat ($urandom_range(0, 2)) begin
        noise; wr_en = 1'b0; load_req = 1'($urandom); go = 1'($urandom);
        exp_set(1, 0, 0, 0, AW'(k), '0, 0); tick;
      end
      noise; wr_en = 1'b1; wr_data = DW'(k); load_req = 1'($urandom);
      exp_set(1, 0, 0, 1, AW'(k), DW'(k), 0); tick;
    end
    noise; wr_en = 1'b1; load_req = 1'b0; go = 1'b0;
    exp_set(0, 0, 0, 0, '0, '0, 0); tick;
    wr_en = 1'b0;
  endtask

  task automatic run_job(input int dly, input bit pre, output int lat);
    int r, i;
    bit cur, prev;
    r = dly - 1;
    noise; go = 1'b1; load_req = 1'b0; conv_ready = pre;
    exp_set(0, 0, 0, 0, '0, '0, 0); tick;
    go = 1'b0;
    noise; conv_ready = rdy(-1, r, pre);
    exp_set(1, 0, 1, 0, '0, '0, 0); tick;
    prev = rdy(-1, r, pre);
    i = 0;
    forever begin
      cur = rdy(i, r, pre);
      noise; conv_ready = cur; go = 1'($urandom);
      exp_set(1, 0, 0, 0, rd_addr, '0, 1); tick;
      if (cur && !prev) break;
      if (i == TO - 1) begin m_err = 1'b1; break; end
      prev = cur; i++;
    end
    lat = i + 2;
    noise; go = 1'b0; conv_ready = 1'($urandom);
    exp_set(0, 1, 0, 0, '0, '0, 0); tick;
  endtask

  initial begin
    int lat;
    rst = 1'b1; load_req = 1'b0; wr_en = 1'b0; go = 1'b0; conv_ready = 1'b0;
    noise;
    tick;
    exp_set(0, 0, 0, 0, '0, '0, 0); chk_on = 1'b1; tick;
    rst = 1'b0;
    repeat (4) begin
      noise; go = 1'($urandom); wr_en = 1'($urandom);
      exp_set(0, 0, 0, 0, '0, '0, 0); tick;
    end
    go = 1'b0; wr_en = 1'b0;

    do_load(1'b0);
    run_job(40, 1'b0, lat);  chk("lat_ready40", 32'(lat), 32'd41);
    run_job(12, 1'b1, lat);  chk("lat_prehigh", 32'(lat), 32'd13);
    run_job(1000, 1'b0, lat); chk("lat_timeout", 32'(lat), 32'(TO + 1));
    chk("model_err_set", 32'(m_err), 32'd1);
    noise; exp_set(0, 0, 0, 0, '0, '0, 0); tick;

    do_load(1'b1);
    run_job(TO, 1'b0, lat);  chk("lat_edge_at_limit", 32'(lat), 32'(TO + 1));
    chk("model_err_clear", 32'(m_err), 32'd0);
    repeat (6) begin
      int d;
      d = $urandom_range(1, TO + 8);
      run_job(d, (d >= 8) ? 1'($urandom) : 1'b0, lat);
    end

    // Reset in the middle of a run.
    noise; go = 1'b1; conv_ready = 1'b0;
    exp_set(0, 0, 0, 0, '0, '0, 0); tick;
    go = 1'b0; noise; exp_set(1, 0, 1, 0, '0, '0, 0); tick;
    repeat (5) begin noise; exp_set(1, 0, 0, 0, rd_addr, '0, 1); tick; end
    noise; rst = 1'b1; exp_set(1, 0, 0, 0, rd_addr, '0, 1); tick;
    rst = 1'b0; m_err = 1'b0;
    repeat (6) begin
      noise; go = 1'b1; wr_en = 1'($urandom); conv_ready = 1'($urandom);
      exp_set(0, 0, 0, 0, '0, '0, 0); tick;
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
